mem_adder_decoder: RTL and testbench
====================================

MEM_ADDER_DECODER -- requirements
Module: mem_adder_decoder

Interface
REQ-001 Parameter PACKET_WIDTH, default 9, total adder packet width: bit [8] spike, bits [7:0] psum.
REQ-002 Parameter PSUM_WIDTH, default 8, psum field width; SHALL equal PACKET_WIDTH-1.
REQ-003 Parameter DEPTH, default 4, FIFO entries; power of two, at least 2.
REQ-004 Parameter NUM_OUT, default 21, output neurons per timestep; AW = $clog2(NUM_OUT).
REQ-005 Port clk, input, 1, single clock; all state updates on the rising edge.
REQ-006 Port rst_n, input, 1, reset, asynchronous and active-low.
REQ-007 Port in_valid, input, 1, upstream packet valid.
REQ-008 Port in_ready, output, 1, decoder can accept a packet.
REQ-009 Port in_packet, input, PACKET_WIDTH, adder-to-MEM packet {spike, psum}.
REQ-010 Port out_valid, output, 1, decoded entry available to memory.
REQ-011 Port out_ready, input, 1, memory accepts the entry.
REQ-012 Port out_spike, output, 1, spike bit of the head entry.
REQ-013 Port out_psum, output, PSUM_WIDTH, psum of the head entry.
REQ-014 Port out_addr, output, AW, memory write index of the head entry.
REQ-015 Port out_last, output, 1, high when out_addr == NUM_OUT-1.

Function
REQ-016 Push occurs when in_valid && in_ready; pop occurs when out_valid && out_ready.
REQ-017 in_ready SHALL be !full, registered-state based, and SHALL NOT depend on out_ready in the same cycle.
REQ-018 When the FIFO is full, pushes SHALL be refused even if a pop occurs in the same cycle.
REQ-019 out_valid SHALL be !empty; out_spike and out_psum SHALL show the FIFO head (first-word fall-through).
REQ-020 Latency: a packet pushed at edge N SHALL be visible on out_* after edge N, with no bubble.
REQ-021 Simultaneous push and pop when not full and not empty SHALL keep occupancy unchanged.
REQ-022 Write and read pointers SHALL wrap from DEPTH-1 to 0; full and empty SHALL be distinguished by an extra pointer bit.
REQ-023 out_addr SHALL increment by 1 on each pop and wrap from NUM_OUT-1 to 0; it SHALL hold on cycles with no pop.
REQ-024 out_last SHALL be combinational from out_addr and independent of out_valid.
REQ-025 Outputs SHALL stay stable while out_valid && !out_ready.
REQ-026 Packet fields SHALL be stored unmodified, with no arithmetic, saturation or reordering.

Reset
REQ-027 While rst_n is low: pointers, occupancy and out_addr are 0; in_ready=1 (reset asserted); out_valid=0; out_spike=0; out_psum=0; out_last=(NUM_OUT==1).
REQ-028 Reset mid-operation SHALL discard all buffered entries immediately, without waiting for a clock edge.
REQ-029 The first push after reset release SHALL be written to out_addr 0.

Configuration
REQ-030 When macro MEM_ADDER_DECODER_SPIKE_COUNT_EN is defined, the block SHALL add output spike_total (width $clog2(NUM_OUT+1)) and output total_valid (1 bit).
REQ-031 With the macro defined, an internal running count SHALL increment on each pop with out_spike=1.
REQ-032 With the macro defined, on a pop with out_last=1, spike_total SHALL load (running count + out_spike), the running count SHALL clear, and total_valid SHALL pulse high for exactly the next cycle.
REQ-033 With the macro defined, reset SHALL clear spike_total, total_valid and the running count to 0.
REQ-034 Without the macro, these ports and their counters SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-035 Single packet: push 9'h1A5, out_ready=1 -> next cycle out_valid=1, out_spike=1, out_psum=8'hA5, out_addr=0; after the pop, out_valid=0 and out_addr=1.
REQ-036 Fill: out_ready=0, push 5 packets with DEPTH=4 -> in_ready=0 after the 4th; the 5th is not accepted; drain order equals push order.
REQ-037 Full plus pop: FIFO full, in_valid=1, out_ready=1 for one cycle -> one pop, no push; occupancy=3; in_ready=1 on the next cycle.
REQ-038 Wrap: stream 22 packets with NUM_OUT=21 -> out_last=1 at the 21st entry (addr 20); the 22nd entry has out_addr=0.
REQ-039 Async reset: assert rst_n=0 mid-clock with 3 entries buffered -> out_valid=0 and in_ready=1 before the next edge; after release, the first push gets addr 0.
REQ-040 With MEM_ADDER_DECODER_SPIKE_COUNT_EN: 21 pops with spike=1 on 7 of them, including the last -> total_valid pulses once and spike_total=7.

Source files
------------

// File: rtl/mem_adder_decoder.sv
// mem_adder_decoder: first-word fall-through FIFO that turns adder packets
// into membrane-memory writes with a wrapping neuron index.
// Optional feature macro: MEM_ADDER_DECODER_SPIKE_COUNT_EN
// (adds spike_total / total_valid, a per-timestep spike count).
module mem_adder_decoder #(
    parameter int PACKET_WIDTH = 9,
    parameter int PSUM_WIDTH   = 8,
    parameter int DEPTH        = 4,
    parameter int NUM_OUT      = 21,
    localparam int AW = (NUM_OUT > 1) ? $clog2(NUM_OUT) : 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [PACKET_WIDTH-1:0] in_packet,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    out_spike,
    output logic [PSUM_WIDTH-1:0]   out_psum,
    output logic [AW-1:0]           out_addr,
    output logic                    out_last
`ifdef MEM_ADDER_DECODER_SPIKE_COUNT_EN
    ,
    output logic [$clog2(NUM_OUT+1)-1:0] spike_total,
    output logic                         total_valid
`endif
);

    localparam int PTRW = $clog2(DEPTH);
    localparam int PW   = PTRW + 1;
    localparam logic [AW-1:0] LAST_ADDR = AW'(NUM_OUT - 1);

    logic [PACKET_WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]           wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]           rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]           addr_q, addr_d;
    logic                    full, empty;
    logic                    push, pop;
    logic [PACKET_WIDTH-1:0] head;

    // Extra MSB on each pointer separates the full and empty cases.
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[PTRW] != rd_ptr_q[PTRW]) &&
                   (wr_ptr_q[PTRW-1:0] == rd_ptr_q[PTRW-1:0]);

    // in_ready looks only at registered pointers, never at out_ready,
    // so a full FIFO refuses a push even when it pops that cycle.
    assign in_ready  = !full;
    assign out_valid = !empty;
    assign push      = in_valid && !full;
    assign pop       = !empty && out_ready;

    assign head = mem_q[rd_ptr_q[PTRW-1:0]];

    // Head fields are masked while empty so reset shows all-zero data.
    assign out_spike = !empty && head[PACKET_WIDTH-1];
    assign out_psum  = empty ? '0 : head[PSUM_WIDTH-1:0];
    assign out_addr  = addr_q;
    assign out_last  = (addr_q == LAST_ADDR);

    // Next-state for pointers and the neuron index.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        addr_d   = addr_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
            if (addr_q == LAST_ADDR) begin
                addr_d = '0;
            end else begin
                addr_d = addr_q + AW'(1);
            end
        end
    end

    // Pointer and index state; reset empties the FIFO immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            addr_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            addr_q   <= addr_d;
        end
    end

    // Storage array; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q[PTRW-1:0]] <= in_packet;
        end
    end

`ifdef MEM_ADDER_DECODER_SPIKE_COUNT_EN
    localparam int CW = $clog2(NUM_OUT + 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] tot_q, tot_d;
    logic          tv_q, tv_d;

    // Count spikes per timestep; publish and restart on the last neuron.
    always_comb begin
        cnt_d = cnt_q;
        tot_d = tot_q;
        tv_d  = 1'b0;
        if (pop) begin
            if (out_last) begin
                tot_d = cnt_q + CW'(out_spike);
                cnt_d = '0;
                tv_d  = 1'b1;
            end else if (out_spike) begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    // Spike-count state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            tot_q <= '0;
            tv_q  <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            tot_q <= tot_d;
            tv_q  <= tv_d;
        end
    end

    assign spike_total = tot_q;
    assign total_valid = tv_q;
`endif

endmodule

// File: tb/tb_mem_adder_decoder.sv
// tb_mem_adder_decoder: scoreboard bench for mem_adder_decoder.
// Expected entries are queued on acceptance and checked by a monitor.
module tb_mem_adder_decoder;

    localparam int PKW     = 9;
    localparam int SW      = 8;
    localparam int DEPTH   = 4;
    localparam int NUM_OUT = 21;
    localparam int AW      = $clog2(NUM_OUT);

    logic           clk = 1'b0;
    logic           rst_n;
    logic           in_valid;
    logic           in_ready;
    logic [PKW-1:0] in_packet;
    logic           out_valid;
    logic           out_ready;
    logic           out_spike;
    logic [SW-1:0]  out_psum;
    logic [AW-1:0]  out_addr;
    logic           out_last;
`ifdef MEM_ADDER_DECODER_SPIKE_COUNT_EN
    logic [$clog2(NUM_OUT+1)-1:0] spike_total;
    logic                         total_valid;
`endif

    always #5 clk = ~clk;

    mem_adder_decoder #(
        .PACKET_WIDTH(PKW),
        .PSUM_WIDTH  (SW),
        .DEPTH       (DEPTH),
        .NUM_OUT     (NUM_OUT)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_packet(in_packet),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_spike(out_spike),
        .out_psum (out_psum),
        .out_addr (out_addr),
        .out_last (out_last)
`ifdef MEM_ADDER_DECODER_SPIKE_COUNT_EN
        ,
        .spike_total(spike_total),
        .total_valid(total_valid)
`endif
    );

    logic [PKW-1:0] exp_q[$];
    logic [PKW-1:0] hd;
    int  n_cmp    = 0;
    int  n_err    = 0;
    int  exp_addr = 0;
    bit  was_full = 1'b0;
`ifdef MEM_ADDER_DECODER_SPIKE_COUNT_EN
    int  spk_cnt  = 0;
    int  spk_tot  = 0;
    bit  tv_exp   = 1'b0;
`endif

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: compares the DUT with the model every cycle, retires pops.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            chk("out_valid", out_valid, exp_q.size() > 0);
            chk("in_ready", in_ready, exp_q.size() < DEPTH);
            chk("out_addr", out_addr, exp_addr);
            chk("out_last", out_last, exp_addr == NUM_OUT - 1);
            if (exp_q.size() > 0) begin
                chk("out_spike", out_spike, exp_q[0][PKW-1]);
                chk("out_psum", out_psum, exp_q[0][SW-1:0]);
            end
`ifdef MEM_ADDER_DECODER_SPIKE_COUNT_EN
            chk("total_valid", total_valid, tv_exp);
            chk("spike_total", spike_total, spk_tot);
            tv_exp = 1'b0;
`endif
            was_full = (exp_q.size() == DEPTH);
            if (exp_q.size() > 0 && out_ready) begin
                hd = exp_q.pop_front();
`ifdef MEM_ADDER_DECODER_SPIKE_COUNT_EN
                if (exp_addr == NUM_OUT - 1) begin
                    spk_tot = spk_cnt + int'(hd[PKW-1]);
                    spk_cnt = 0;
                    tv_exp  = 1'b1;
                end else begin
                    spk_cnt += int'(hd[PKW-1]);
                end
`endif
                exp_addr = (exp_addr + 1) % NUM_OUT;
            end
        end
    end

    // Acceptance: a packet is queued when offered and the model is not full.
    always @(posedge clk) begin
        if (rst_n === 1'b1 && in_valid && !was_full) begin
            exp_q.push_back(in_packet);
        end
    end

    task automatic cyc(input bit v, input logic [PKW-1:0] p, input bit r);
        in_valid  = v;
        in_packet = p;
        out_ready = r;
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        for (int i = 0; i < 40 && exp_q.size() > 0; i++) begin
            cyc(1'b0, '0, 1'b1);
        end
        chk("drain_left", exp_q.size(), 0);
        cyc(1'b0, '0, 1'b0);
    endtask

    task automatic model_clear();
        exp_q.delete();
        exp_addr = 0;
        was_full = 1'b0;
`ifdef MEM_ADDER_DECODER_SPIKE_COUNT_EN
        spk_cnt = 0;
        spk_tot = 0;
        tv_exp  = 1'b0;
`endif
    endtask

    task automatic async_reset();
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_psum", out_psum, 0);
        chk("rst_out_spike", out_spike, 0);
        chk("rst_out_addr", out_addr, 0);
        chk("rst_out_last", out_last, 0);
        model_clear();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_packet = '0;
        out_ready = 1'b0;
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        chk("init_out_valid", out_valid, 0);
        chk("init_in_ready", in_ready, 1);
        chk("init_out_addr", out_addr, 0);
        chk("init_out_psum", out_psum, 0);
        rst_n = 1'b1;
        cyc(1'b0, '0, 1'b0);

        // single packet
        cyc(1'b1, 9'h1A5, 1'b1);
        cyc(1'b0, '0, 1'b1);
        cyc(1'b0, '0, 1'b1);
        chk("single_addr", out_addr, 1);

        // fill past capacity, then full plus pop
        for (int i = 0; i < 5; i++) begin
            cyc(1'b1, PKW'(9'h040 + i * 9'h05F), 1'b0);
        end
        chk("full_in_ready", in_ready, 0);
        cyc(1'b1, 9'h0FF, 1'b1);
        cyc(1'b0, '0, 1'b0);
        chk("after_pop_in_ready", in_ready, 1);
        drain();

        // reset with three entries buffered, then first push
        for (int i = 0; i < 3; i++) begin
            cyc(1'b1, PKW'($urandom), 1'b0);
        end
        async_reset();
        cyc(1'b1, 9'h0C3, 1'b0);
        cyc(1'b0, '0, 1'b0);
        chk("post_rst_addr", out_addr, 0);
        drain();

        // wrap across a full timestep
        async_reset();
        for (int i = 0; i < 22; i++) begin
            cyc(1'b1, PKW'($urandom), 1'b1);
        end
        drain();

        // one timestep with seven spikes, last one included
        async_reset();
        for (int i = 0; i < NUM_OUT; i++) begin
            cyc(1'b1, {(i % 3 == 2), 8'($urandom)}, 1'b1);
        end
        drain();

        // randomized traffic with backpressure
        for (int i = 0; i < 800; i++) begin
            cyc(1'($urandom_range(0, 1)), PKW'($urandom),
                ($urandom_range(0, 3) != 0));
        end
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
